// File: rtl/irq_aggregator.sv
// irq_aggregator: latches NUM_SRC interrupt sources into pending bits, applies a
// per-source mask and drives a registered irq plus the lowest-index active source.
// Optional macro IRQ_AGGR_SYNC_EN: when defined, every source passes through a
// two-flop synchronizer before edge/level detection (source->irq latency 4 cycles
// instead of 2; ack and mask latency are unaffected).
module irq_aggregator #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic [NUM_SRC-1:0] edge_sel,
   input  logic [NUM_SRC-1:0] mask,
   input  logic               ack,
   input  logic [ID_W-1:0]    ack_id,
   output logic [NUM_SRC-1:0] pending_o,
   output logic               irq,
   output logic [ID_W-1:0]    irq_id
);

   // Source as seen by the detection logic (raw or synchronized)
   logic [NUM_SRC-1:0] src_s;

   // Previous-cycle copy of src_s, used for rising-edge detection
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] src_d;

   // Pending register and its next value
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;

   // Per-bit set/clear terms and the unmasked-pending view
   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] clear_vec;
   logic [NUM_SRC-1:0] active_vec;

   // Zero-extended ack index so out-of-range ids simply never match a source
   logic [31:0]        ack_id_ext;

   // Registered request outputs
   logic               irq_q;
   logic               irq_d;
   logic [ID_W-1:0]    irq_id_q;
   logic [ID_W-1:0]    irq_id_d;

`ifdef IRQ_AGGR_SYNC_EN
   logic [NUM_SRC-1:0] sync1_q;
   logic [NUM_SRC-1:0] sync1_d;
   logic [NUM_SRC-1:0] sync2_q;
   logic [NUM_SRC-1:0] sync2_d;

   // Synchronizer chain inputs: raw source into stage 1, stage 1 into stage 2
   always_comb begin
      sync1_d = src_i;
      sync2_d = sync1_q;
   end

   // Two-flop synchronizer; cleared on reset so a source high across reset
   // release is seen as a fresh rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src_i;
`endif

   assign ack_id_ext = 32'(ack_id);

   // Edge history simply tracks the sampled source one cycle behind
   always_comb begin
      src_d = src_s;
   end

   // Per-source set (edge or level) and clear (matching ack) terms
   always_comb begin
      set_vec   = '0;
      clear_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (edge_sel[i]) begin
            set_vec[i] = src_s[i] & ~src_q[i];
         end else begin
            set_vec[i] = src_s[i];
         end
         clear_vec[i] = ack & (ack_id_ext == 32'(i));
      end
   end

   // Pending update: a same-cycle set beats the clear, so a still-high level
   // source or a fresh edge re-pends without a gap
   always_comb begin
      pending_d = set_vec | (pending_q & ~clear_vec);
   end

   // Request generation: any unmasked pending bit raises irq, and the id is the
   // lowest such index; with nothing active the last id is kept
   always_comb begin
      active_vec = pending_q & ~mask;
      irq_d      = |active_vec;
      irq_id_d   = irq_id_q;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active_vec[i]) begin
            irq_id_d = ID_W'(i);
         end
      end
   end

   // State registers with synchronous reset discarding in-flight sources and acks
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q     <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         src_q     <= src_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
      end
   end

   assign pending_o = pending_q;
   assign irq       = irq_q;
   assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: scoreboard bench for irq_aggregator. Each scenario task walks a
// table of per-cycle stimulus rows; the expected outputs of a row are pushed when
// the row is driven and popped/compared once the clock edge has produced them.
// A second 6-source instance shares the stimulus to exercise out-of-range ack ids.
module tb_irq_aggregator;

`ifdef IRQ_AGGR_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   typedef struct packed {
      logic       rst;
      logic [7:0] src;
      logic [7:0] msk;
      logic       ack;
      logic [2:0] aid;
      logic       settle;
      logic [7:0] pend;
      logic       irq;
      logic [2:0] id;
   } row_t;

   typedef struct packed {
      logic [7:0] pend;
      logic       irq;
      logic [2:0] id;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] src_i;
   logic [7:0] edge_sel;
   logic [7:0] mask;
   logic       ack;
   logic [2:0] ack_id;
   logic [7:0] pending_o;
   logic       irq;
   logic [2:0] irq_id;

   logic       use_alt;
   logic [2:0] alt_id;
   logic [2:0] ack_id6;
   logic [5:0] pending6;
   logic       irq6;
   logic [2:0] irq_id6;

   exp_t       exp_q[$];
   int         n_tests;
   int         n_fail;

   assign ack_id6 = use_alt ? alt_id : ack_id;

   irq_aggregator #(.NUM_SRC(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .src_i     (src_i),
      .edge_sel  (edge_sel),
      .mask      (mask),
      .ack       (ack),
      .ack_id    (ack_id),
      .pending_o (pending_o),
      .irq       (irq),
      .irq_id    (irq_id)
   );

   irq_aggregator #(.NUM_SRC(6)) u_dut6 (
      .clk       (clk),
      .rst       (rst),
      .src_i     (src_i[5:0]),
      .edge_sel  (edge_sel[5:0]),
      .mask      (mask[5:0]),
      .ack       (ack),
      .ack_id    (ack_id6),
      .pending_o (pending6),
      .irq       (irq6),
      .irq_id    (irq_id6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      automatic row_t rows [2] = '{
         '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0},
         '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL reset row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_edge();
      automatic row_t rows [4] = '{
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b1, 8'h08, 1'b0, 3'd0},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 3'd3},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 3'd3},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd3}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL edge row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_level();
      automatic row_t rows [7] = '{
         '{1'b0, 8'h20, 8'h00, 1'b0, 3'd0, 1'b1, 8'h20, 1'b0, 3'd3},
         '{1'b0, 8'h20, 8'h00, 1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 3'd5},
         '{1'b0, 8'h20, 8'h00, 1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 3'd5},
         '{1'b0, 8'h20, 8'h00, 1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 3'd5},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 3'd5},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 1'b0, 8'h00, 1'b1, 3'd5},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd5}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL level row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_priority();
      automatic row_t rows [6] = '{
         '{1'b0, 8'h44, 8'h00, 1'b0, 3'd0, 1'b1, 8'h44, 1'b0, 3'd5},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h44, 1'b1, 3'd2},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 1'b0, 8'h40, 1'b1, 3'd2},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h40, 1'b1, 3'd6},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd6, 1'b0, 8'h00, 1'b1, 3'd6},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd6}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL priority row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_mask();
      automatic row_t rows [5] = '{
         '{1'b0, 8'h01, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 3'd6},
         '{1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h01, 1'b0, 3'd6},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 3'd0},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 3'd0},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL mask row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_ack_collision();
      automatic row_t rows [6] = '{
         '{1'b0, 8'h02, 8'h00, 1'b0, 3'd0, 1'b1, 8'h02, 1'b0, 3'd0},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 8'h02, 1'b1, 3'd1},
         '{1'b0, 8'h02, 8'h00, 1'b1, 3'd1, 1'b1, 8'h02, 1'b1, 3'd1},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h02, 1'b1, 3'd1},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 1'b0, 8'h00, 1'b1, 3'd1},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd1}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL collision row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      automatic row_t rows [9] = '{
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b1, 8'h08, 1'b0, 3'd1},
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 3'd3},
         '{1'b1, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0},
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b1, 8'h08, 1'b0, 3'd0},
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 3'd3},
         '{1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 3'd3},
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd3},
         '{1'b0, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd3},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 3'd3}
      };
      exp_t e;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid;
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_mid row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
      end
      ack = 1'b0;
   endtask

   // Ack to a non-pending bit on the 8-source instance; ack ids 6 and 7 on the
   // 6-source instance are beyond its range and must be ignored
   task automatic test_ack_range();
      automatic row_t rows [6] = '{
         '{1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 1'b1, 8'h10, 1'b0, 3'd3},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h10, 1'b1, 3'd4},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd7, 1'b0, 8'h10, 1'b1, 3'd4},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd7, 1'b0, 8'h10, 1'b1, 3'd4},
         '{1'b0, 8'h00, 8'h00, 1'b1, 3'd4, 1'b0, 8'h00, 1'b1, 3'd4},
         '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd4}
      };
      automatic logic [2:0] alt [6] = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd4, 3'd0};
      exp_t e;
      use_alt = 1'b1;
      foreach (rows[r]) begin
         rst = rows[r].rst; src_i = rows[r].src; mask = rows[r].msk; ack = 1'b0;
         if (rows[r].settle) repeat (SYNC_LAT) step();
         ack = rows[r].ack; ack_id = rows[r].aid; alt_id = alt[r];
         exp_q.push_back('{rows[r].pend, rows[r].irq, rows[r].id});
         step();
         e = exp_q.pop_front();
         n_tests++;
         if ({pending_o, irq, irq_id} !== e) begin
            n_fail++;
            $display("[TB] FAIL ack_range row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending_o, irq, irq_id, e.pend, e.irq, e.id);
         end
         n_tests++;
         if ({pending6, irq6, irq_id6} !== {e.pend[5:0], e.irq, e.id}) begin
            n_fail++;
            $display("[TB] FAIL ack_range6 row %0d: got pending=%h irq=%b id=%0d, expected pending=%h irq=%b id=%0d",
                     r, pending6, irq6, irq_id6, e.pend[5:0], e.irq, e.id);
         end
      end
      ack = 1'b0;
      use_alt = 1'b0;
   endtask

   // Count clock edges from a rising edge on source 7 until irq asserts
   task automatic test_latency();
      int cnt;
      cnt = 0;
      rst = 1'b0; mask = 8'h00; ack = 1'b0;
      src_i = 8'h80;
      while (cnt < 20 && irq !== 1'b1) begin
         step();
         cnt++;
      end
      n_tests++;
      if (cnt != 2 + SYNC_LAT || irq_id !== 3'd7) begin
         n_fail++;
         $display("[TB] FAIL latency: got %0d cycles id=%0d, expected %0d cycles id=7",
                  cnt, irq_id, 2 + SYNC_LAT);
      end
      src_i = 8'h00;
      ack = 1'b1; ack_id = 3'd7;
      step();
      ack = 1'b0;
      step();
      step();
      n_tests++;
      if (irq !== 1'b0 || pending_o !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL latency_clear: got pending=%h irq=%b, expected pending=00 irq=0",
                  pending_o, irq);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      src_i    = 8'h00;
      edge_sel = 8'hDF;
      mask     = 8'h00;
      ack      = 1'b0;
      ack_id   = 3'd0;
      use_alt  = 1'b0;
      alt_id   = 3'd0;
      #1;
      test_reset();
      test_edge();
      test_level();
      test_priority();
      test_mask();
      test_ack_collision();
      test_reset_mid();
      test_ack_range();
      test_latency();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
